// File: rtl/display_pkg.sv
// Shared types and constants for the display scan controller.
// next_idx() finds the next enabled digit above cur, wrapping 3->0.
package display_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBlank,
    StShow
  } scan_state_e;

  localparam logic [1:0] PD = 2'd0;
  localparam logic [1:0] PU = 2'd1;
  localparam logic [1:0] TD = 2'd2;
  localparam logic [1:0] TU = 2'd3;

  localparam int unsigned BlankCycDefault = 4;

  // Scans cur+4 down to cur+1 so the nearest enabled index is the last one kept.
  function automatic logic [1:0] next_idx(input logic [1:0] cur, input logic [3:0] mask);
    logic [1:0] res;
    logic [1:0] cand;
    res = cur;
    for (int i = 4; i >= 1; i--) begin
      cand = cur + 2'(i);
      if (mask[cand]) res = cand;
    end
    return res;
  endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Control and display-drive bundle of the scan controller.
// master drives the scan controls; slave is the controller itself.
interface display_scan_ctrl_if #(
  parameter int unsigned DIV_W = 16
);
  logic             en;
  logic [DIV_W-1:0] div_cfg;
  logic [3:0]       digit_mask;
  logic [15:0]      data_in;
  logic             load;
  logic [1:0]       sel;
  logic [3:0]       digit_n;
  logic [3:0]       nibble;
  logic             blank;
  logic             frame_done;

  modport master (
    output en, div_cfg, digit_mask, data_in, load,
    input  sel, digit_n, nibble, blank, frame_done
  );

  modport slave (
    input  en, div_cfg, digit_mask, data_in, load,
    output sel, digit_n, nibble, blank, frame_done
  );
endinterface

// File: rtl/scan_prescaler.sv
// Loadable down-counter shared by the blank and show dwells.
// tc is high while the count sits at zero.
module scan_prescaler #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  output logic             tc
);
  logic [Width-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign tc = (cnt_q == '0);
endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner: blank dead-time, then a per-digit dwell.
// All outputs are registered copies of the next-state decode.
module display_scan_ctrl import display_pkg::*; #(
  parameter int unsigned DIV_W     = 16,
  parameter int unsigned BLANK_CYC = BlankCycDefault
) (
  input logic                clk,
  input logic                rst,
  display_scan_ctrl_if.slave bus
);
  localparam logic [DIV_W-1:0] BlankLoad = DIV_W'(BLANK_CYC - 1);

  scan_state_e state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] pending_q, active_q, active_d;
  logic [3:0]  digit_n_q, digit_n_d;
  logic [3:0]  nibble_q, nibble_d;
  logic        blank_q, blank_d;
  logic        frame_done_q, frame_done_d;
  logic        pre_load, pre_tc;
  logic [DIV_W-1:0] pre_val;
  logic [1:0]  nxt;

  scan_prescaler #(
    .Width(DIV_W)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .load    (pre_load),
    .load_val(pre_val),
    .tc      (pre_tc)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    active_d     = active_q;
    pre_load     = 1'b0;
    pre_val      = '0;
    frame_done_d = 1'b0;
    nxt          = next_idx(idx_q, bus.digit_mask);
    if (!bus.en || bus.digit_mask == 4'b0000) begin
      state_d = StIdle;
      idx_d   = PD;
    end else begin
      case (state_q)
        StIdle: begin
          state_d  = StBlank;
          idx_d    = next_idx(TU, bus.digit_mask);
          active_d = pending_q;
          pre_load = 1'b1;
          pre_val  = BlankLoad;
        end
        StBlank: begin
          if (pre_tc) begin
            state_d  = StShow;
            pre_load = 1'b1;
            pre_val  = bus.div_cfg;
          end
        end
        StShow: begin
          if (pre_tc) begin
            state_d  = StBlank;
            idx_d    = nxt;
            pre_load = 1'b1;
            pre_val  = BlankLoad;
            // Not moving upward means the frame wrapped (a lone digit wraps onto itself).
            if (nxt <= idx_q) begin
              frame_done_d = 1'b1;
              active_d     = pending_q;
            end
          end
        end
        default: begin
          state_d = StIdle;
          idx_d   = PD;
        end
      endcase
    end

    digit_n_d = 4'hF;
    nibble_d  = 4'h0;
    blank_d   = 1'b1;
    if (state_d == StShow) begin
      digit_n_d = ~(4'b0001 << idx_d);
      nibble_d  = active_d[{idx_d, 2'b00} +: 4];
      blank_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      idx_q        <= PD;
      pending_q    <= '0;
      active_q     <= '0;
      digit_n_q    <= 4'hF;
      nibble_q     <= 4'h0;
      blank_q      <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      active_q     <= active_d;
      digit_n_q    <= digit_n_d;
      nibble_q     <= nibble_d;
      blank_q      <= blank_d;
      frame_done_q <= frame_done_d;
      if (bus.load) pending_q <= bus.data_in;
    end
  end

  assign bus.sel        = idx_q;
  assign bus.digit_n    = digit_n_q;
  assign bus.nibble     = nibble_q;
  assign bus.blank      = blank_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: expected digits are queued as stimulus is applied
// and popped as each digit dwell is observed.
module tb_display_scan_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  typedef struct packed {
    logic [1:0] sel;
    logic [3:0] nib;
  } exp_t;

  exp_t sb[$];

  display_scan_ctrl_if #(.DIV_W(16)) bus ();

  display_scan_ctrl #(
    .DIV_W    (16),
    .BLANK_CYC(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Called at a negedge; consumes the remaining blank cycles and one show dwell.
  task automatic wait_show(output logic [1:0] s, output logic [3:0] nib, output logic [3:0] dn,
                           output int blen, output int slen, output int fdp, output int fdc,
                           output bit ok);
    int guard;
    blen = 0; slen = 0; fdp = -1; fdc = 0; ok = 1'b1; guard = 0;
    s = 2'b00; nib = 4'h0; dn = 4'h0;
    while (bus.blank === 1'b1 && guard < 200) begin
      if (bus.frame_done === 1'b1 && fdp < 0) begin
        fdp = blen;
        fdc = cyc;
      end
      blen++; guard++;
      @(negedge clk);
    end
    s = bus.sel; nib = bus.nibble; dn = bus.digit_n;
    while (bus.blank === 1'b0 && guard < 200) begin
      slen++; guard++;
      @(negedge clk);
    end
    if (guard >= 200) ok = 1'b0;
  endtask

  task automatic stop_scan();
    bus.en = 1'b0;
    bus.load = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL reset_sel got %b want 00", bus.sel); end
    checks++; if (bus.digit_n !== 4'hF) begin errors++; $display("FAIL reset_digit_n got %b want 1111", bus.digit_n); end
    checks++; if (bus.nibble !== 4'h0) begin errors++; $display("FAIL reset_nibble got %h want 0", bus.nibble); end
    checks++; if (bus.blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b want 1", bus.blank); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_scan();
    exp_t e;
    logic [1:0] s; logic [3:0] nib, dn;
    int blen, slen, fdp, fdc, fd_prev;
    bit ok;
    stop_scan();
    bus.load = 1'b1; bus.data_in = 16'h8765;
    @(negedge clk);
    bus.load = 1'b0;
    bus.digit_mask = 4'hF; bus.div_cfg = 16'd2; bus.en = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      for (int d = 0; d < 4; d++) begin
        e.sel = 2'(d); e.nib = 4'(5 + d);
        sb.push_back(e);
      end
    end
    fd_prev = -1;
    for (int i = 0; i < 12; i++) begin
      wait_show(s, nib, dn, blen, slen, fdp, fdc, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL full_timeout digit %0d", i); end
      checks++; if (s !== e.sel) begin errors++; $display("FAIL full_sel digit %0d got %b want %b", i, s, e.sel); end
      checks++; if (nib !== e.nib) begin errors++; $display("FAIL full_nibble digit %0d got %h want %h", i, nib, e.nib); end
      checks++; if (dn !== ~(4'b0001 << e.sel)) begin errors++; $display("FAIL full_digit_n digit %0d got %b", i, dn); end
      checks++; if (blen != 4) begin errors++; $display("FAIL full_blank_len digit %0d got %0d want 4", i, blen); end
      checks++; if (slen != 3) begin errors++; $display("FAIL full_show_len digit %0d got %0d want 3", i, slen); end
      checks++;
      if (fdp != ((i == 4 || i == 8) ? 0 : -1)) begin
        errors++; $display("FAIL full_frame_done digit %0d got pos %0d", i, fdp);
      end
      if (fdp == 0) begin
        if (fd_prev >= 0) begin
          checks++;
          if (fdc - fd_prev != 28) begin
            errors++; $display("FAIL full_frame_period got %0d want 28", fdc - fd_prev);
          end
        end
        fd_prev = fdc;
      end
    end
  endtask

  task automatic test_load_mid_frame();
    exp_t e;
    logic [1:0] s; logic [3:0] nib, dn;
    int blen, slen, fdp, fdc;
    bit ok;
    logic [15:0] vals;
    stop_scan();
    bus.digit_mask = 4'hF; bus.div_cfg = 16'd2; bus.en = 1'b1;
    @(negedge clk);
    vals = 16'h8765;
    for (int d = 0; d < 4; d++) begin e.sel = 2'(d); e.nib = vals[d*4 +: 4]; sb.push_back(e); end
    wait_show(s, nib, dn, blen, slen, fdp, fdc, ok);
    bus.load = 1'b1; bus.data_in = 16'h4321;
    vals = 16'h4321;
    for (int d = 0; d < 4; d++) begin e.sel = 2'(d); e.nib = vals[d*4 +: 4]; sb.push_back(e); end
    @(negedge clk);
    bus.load = 1'b0;
    e = sb.pop_front();
    checks++; if (nib !== e.nib) begin errors++; $display("FAIL load_nibble digit 0 got %h want %h", nib, e.nib); end
    for (int i = 1; i < 8; i++) begin
      wait_show(s, nib, dn, blen, slen, fdp, fdc, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL load_timeout digit %0d", i); end
      checks++; if (s !== e.sel) begin errors++; $display("FAIL load_sel digit %0d got %b want %b", i, s, e.sel); end
      checks++; if (nib !== e.nib) begin errors++; $display("FAIL load_nibble digit %0d got %h want %h", i, nib, e.nib); end
      checks++;
      if (fdp != ((i == 4) ? 0 : -1)) begin
        errors++; $display("FAIL load_frame_done digit %0d got pos %0d", i, fdp);
      end
    end
  endtask

  task automatic test_mask_0101();
    exp_t e;
    logic [1:0] s; logic [3:0] nib, dn;
    int blen, slen, fdp, fdc;
    bit ok;
    stop_scan();
    bus.digit_mask = 4'b0101; bus.div_cfg = 16'd1; bus.en = 1'b1;
    @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      e.sel = 2'd0; e.nib = 4'h1; sb.push_back(e);
      e.sel = 2'd2; e.nib = 4'h3; sb.push_back(e);
    end
    for (int i = 0; i < 6; i++) begin
      wait_show(s, nib, dn, blen, slen, fdp, fdc, ok);
      e = sb.pop_front();
      checks++; if (!ok) begin errors++; $display("FAIL mask_timeout digit %0d", i); end
      checks++; if (s !== e.sel) begin errors++; $display("FAIL mask_sel digit %0d got %b want %b", i, s, e.sel); end
      checks++; if (nib !== e.nib) begin errors++; $display("FAIL mask_nibble digit %0d got %h want %h", i, nib, e.nib); end
      checks++; if (dn !== ~(4'b0001 << e.sel)) begin errors++; $display("FAIL mask_digit_n digit %0d got %b", i, dn); end
      checks++; if (slen != 2) begin errors++; $display("FAIL mask_show_len digit %0d got %0d want 2", i, slen); end
      checks++;
      if (fdp != ((i == 2 || i == 4) ? 0 : -1)) begin
        errors++; $display("FAIL mask_frame_done digit %0d got pos %0d", i, fdp);
      end
    end
  endtask

  task automatic test_abort();
    logic [1:0] s; logic [3:0] nib, dn;
    int blen, slen, fdp, fdc, guard;
    bit ok, fd_seen;
    stop_scan();
    bus.digit_mask = 4'hF; bus.div_cfg = 16'd2; bus.en = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!(bus.blank === 1'b0 && bus.sel === 2'd2) && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    checks++; if (guard >= 100) begin errors++; $display("FAIL abort_timeout waiting for td show"); end
    bus.en = 1'b0;
    @(negedge clk);
    checks++; if (bus.digit_n !== 4'hF) begin errors++; $display("FAIL abort_digit_n got %b want 1111", bus.digit_n); end
    checks++; if (bus.blank !== 1'b1) begin errors++; $display("FAIL abort_blank got %b want 1", bus.blank); end
    checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL abort_sel got %b want 00", bus.sel); end
    fd_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.frame_done === 1'b1) fd_seen = 1'b1;
      @(negedge clk);
    end
    checks++; if (fd_seen) begin errors++; $display("FAIL abort_frame_done got 1 want 0"); end
    bus.en = 1'b1;
    @(negedge clk);
    wait_show(s, nib, dn, blen, slen, fdp, fdc, ok);
    checks++; if (s !== 2'd0) begin errors++; $display("FAIL abort_restart_sel got %b want 00", s); end
    checks++; if (blen != 4) begin errors++; $display("FAIL abort_restart_blank got %0d want 4", blen); end
    checks++; if (fdp != -1) begin errors++; $display("FAIL abort_restart_frame_done got pos %0d", fdp); end
  endtask

  task automatic test_div_sample();
    logic [1:0] s; logic [3:0] nib, dn;
    int blen, slen, fdp, fdc, guard, n;
    bit ok;
    stop_scan();
    bus.digit_mask = 4'hF; bus.div_cfg = 16'd3; bus.en = 1'b1;
    @(negedge clk);
    guard = 0;
    while (bus.blank === 1'b1 && guard < 100) begin guard++; @(negedge clk); end
    bus.div_cfg = 16'd0;
    n = 0;
    while (bus.blank === 1'b0 && n < 100) begin n++; @(negedge clk); end
    checks++; if (n != 4) begin errors++; $display("FAIL div_hold_show_len got %0d want 4", n); end
    wait_show(s, nib, dn, blen, slen, fdp, fdc, ok);
    checks++; if (slen != 1) begin errors++; $display("FAIL div_next_show_len got %0d want 1", slen); end
    checks++; if (s !== 2'd1) begin errors++; $display("FAIL div_next_sel got %b want 01", s); end
  endtask

  task automatic test_single_digit();
    logic [1:0] s; logic [3:0] nib, dn;
    int blen, slen, fdp, fdc, fd_prev;
    bit ok;
    stop_scan();
    bus.load = 1'b1; bus.data_in = 16'hA000;
    @(negedge clk);
    bus.load = 1'b0;
    bus.digit_mask = 4'b1000; bus.div_cfg = 16'd0; bus.en = 1'b1;
    @(negedge clk);
    fd_prev = -1;
    for (int i = 0; i < 5; i++) begin
      wait_show(s, nib, dn, blen, slen, fdp, fdc, ok);
      checks++; if (s !== 2'd3) begin errors++; $display("FAIL single_sel digit %0d got %b want 11", i, s); end
      checks++; if (dn !== 4'b0111) begin errors++; $display("FAIL single_digit_n digit %0d got %b want 0111", i, dn); end
      checks++; if (nib !== 4'hA) begin errors++; $display("FAIL single_nibble digit %0d got %h want a", i, nib); end
      checks++; if (slen != 1) begin errors++; $display("FAIL single_show_len digit %0d got %0d want 1", i, slen); end
      checks++;
      if (fdp != ((i == 0) ? -1 : 0)) begin
        errors++; $display("FAIL single_frame_done digit %0d got pos %0d", i, fdp);
      end
      if (fdp == 0) begin
        if (fd_prev >= 0) begin
          checks++;
          if (fdc - fd_prev != 5) begin
            errors++; $display("FAIL single_frame_period got %0d want 5", fdc - fd_prev);
          end
        end
        fd_prev = fdc;
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] s; logic [3:0] nib, dn;
    int blen, slen, fdp, fdc, guard;
    bit ok;
    stop_scan();
    bus.digit_mask = 4'hF; bus.div_cfg = 16'd2; bus.en = 1'b1;
    @(negedge clk);
    guard = 0;
    while (!(bus.blank === 1'b1 && bus.sel === 2'd1) && guard < 100) begin
      guard++;
      @(negedge clk);
    end
    checks++; if (guard >= 100) begin errors++; $display("FAIL arst_timeout waiting for pu blank"); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.sel !== 2'b00) begin errors++; $display("FAIL arst_sel got %b want 00", bus.sel); end
    checks++; if (bus.digit_n !== 4'hF) begin errors++; $display("FAIL arst_digit_n got %b want 1111", bus.digit_n); end
    checks++; if (bus.blank !== 1'b1) begin errors++; $display("FAIL arst_blank got %b want 1", bus.blank); end
    checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL arst_frame_done got %b want 0", bus.frame_done); end
    bus.en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.en = 1'b1;
    @(negedge clk);
    wait_show(s, nib, dn, blen, slen, fdp, fdc, ok);
    checks++; if (s !== 2'd0) begin errors++; $display("FAIL arst_restart_sel got %b want 00", s); end
    checks++; if (nib !== 4'h0) begin errors++; $display("FAIL arst_cleared_nibble got %h want 0", nib); end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.div_cfg = '0;
    bus.digit_mask = 4'h0;
    bus.data_in = 16'h0;
    bus.load = 1'b0;
    test_reset();
    test_full_scan();
    test_load_mid_frame();
    test_mask_0101();
    test_abort();
    test_div_sample();
    test_single_digit();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 16, prescaler width.
REQ-002 SHALL have parameter BLANK_CYC, default 4, dead-time cycles between digits (legal range 1..255).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  scan enable.
REQ-006 SHALL have port div_cfg  input  DIV_W  dwell length minus one per digit.
REQ-007 SHALL have port digit_mask  input  4  per-digit enable; bit0=pd, bit1=pu, bit2=td, bit3=tu.
REQ-008 SHALL have port data_in  input  16  nibbles {tu,td,pu,pd}.
REQ-009 SHALL have port load  input  1  capture data_in into pending buffer.
REQ-010 SHALL have port sel  output  2  digit select; sel[1] drives clky, sel[0] drives clkz; 00=pd, 01=pu, 10=td, 11=tu.
REQ-011 SHALL have port digit_n  output  4  one-hot active-low digit strobe, same bit order as digit_mask.
REQ-012 SHALL have port nibble  output  4  active-buffer nibble of the current digit.
REQ-013 SHALL have port blank  output  1  high when no digit strobed.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse at frame wrap.

Function
REQ-015 SHALL implement FSM states IDLE, BLANK and SHOW.
REQ-016 SHALL, in IDLE, drive digit_n=1111, blank=1, sel=00 and nibble=0; IDLE->BLANK when en=1 and digit_mask!=0, selecting the lowest enabled index.
REQ-017 SHALL, in BLANK, hold digit_n=1111 and blank=1 with sel at the target index for exactly BLANK_CYC cycles, then go to SHOW.
REQ-018 SHALL, in SHOW, drive digit_n[sel]=0 with all other bits 1, blank=0 and nibble=active[sel], for exactly div_cfg+1 cycles; div_cfg=0 gives a 1-cycle dwell.
REQ-019 SHALL sample div_cfg on SHOW entry; changes during SHOW take effect at the next digit.
REQ-020 SHALL advance, after SHOW, to the next index with digit_mask set, searching upward with wrap 3->0, using digit_mask sampled at that cycle, then enter BLANK.
REQ-021 SHALL, when the next index is <= the current index (wrap, including a single enabled digit), pulse frame_done for the first BLANK cycle and copy pending to active in that same cycle.
REQ-022 SHALL set pending to data_in on any cycle with load=1, regardless of state; load at a wrap cycle SHALL reach active at the following wrap.
REQ-023 SHALL also copy pending to active on the IDLE->BLANK transition.
REQ-024 SHALL go to IDLE on the next edge when en=0 or digit_mask=0 in any state, aborting any dwell mid-cycle without a frame_done pulse.
REQ-025 SHALL never assert more than one digit_n bit low, and SHALL never assert any digit_n bit low while blank=1.
REQ-026 SHALL register all outputs, with no combinational path from inputs to outputs.

Reset
REQ-027 SHALL, on rst=1 asynchronously, force IDLE, prescaler=0, pending=0, active=0, sel=00, digit_n=1111, nibble=0, blank=1 and frame_done=0.
REQ-028 SHALL require at least one clk edge after rst release before leaving IDLE.

Structure
REQ-029 SHALL take the state enum, the digit index constants (PD=0, PU=1, TD=2, TU=3) and the BLANK_CYC default from shared package display_pkg.
REQ-030 SHALL instantiate one sub-module, scan_prescaler: a loadable down-counter with a terminal-count flag, used for both the BLANK and SHOW dwell counts.

Verification
REQ-031 SHALL cover: mask=1111, div_cfg=2, BLANK_CYC=4 -> sel 00,01,10,11 repeating, 4 blank + 3 show cycles each, frame_done every 28 cycles.
REQ-032 SHALL cover: mask=0101 -> only pd and td strobed, sel never 01 or 11 during SHOW.
REQ-033 SHALL cover: load data_in=0x4321 mid-frame -> nibble continues showing the old data until frame_done, then shows 1,2,3,4.
REQ-034 SHALL cover: en dropped during SHOW of td -> next cycle digit_n=1111, blank=1 and no frame_done; re-enable restarts at pd.
REQ-035 SHALL cover: rst asserted asynchronously mid-BLANK -> all outputs at reset values before the next clk edge.
REQ-036 SHALL cover: mask=1000, div_cfg=0 -> tu strobed 1 cycle per 5-cycle period, frame_done every 5 cycles.
